// File: rtl/dense_layer_engine.sv
// Sequencer and MAC for one fully connected int4 layer. It computes one neuron at a time,
// requantizes the result, and writes it into the next layer's activation RAM.
module dense_layer_engine #(
  parameter int unsigned N_IN  = 784,
  parameter int unsigned N_OUT = 10,
  parameter int unsigned ACT_W = 4,
  parameter int unsigned W_W   = 4,
  parameter int unsigned B_W   = 16,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned SHIFT = 4,
  parameter int unsigned RELU  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(N_IN)-1:0]       act_addr,
  input  logic [ACT_W-1:0]              act_data,
  output logic [$clog2(N_IN*N_OUT)-1:0] w_addr,
  input  logic [W_W-1:0]                w_data,
  output logic [$clog2(N_OUT)-1:0]      b_addr,
  input  logic [B_W-1:0]                b_data,
  output logic                          out_wen,
  output logic [$clog2(N_OUT)-1:0]      out_addr,
  output logic [ACT_W-1:0]              out_data
);

  localparam int unsigned AW     = $clog2(N_IN);
  localparam int unsigned WAW    = $clog2(N_IN*N_OUT);
  localparam int unsigned BAW    = $clog2(N_OUT);
  localparam int unsigned PROD_W = W_W + ACT_W + 1;
  localparam int unsigned SUM_W  = ACC_W + 1;

  localparam logic signed [SUM_W-1:0] UMAX = SUM_W'((2 ** ACT_W) - 1);
  localparam logic signed [SUM_W-1:0] SMAX = SUM_W'((2 ** (ACT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SMIN = ~SMAX;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;

  state_t                   state, state_d;
  logic                     busy_d, done_d, out_wen_d;
  logic [AW-1:0]            act_addr_d;
  logic [WAW-1:0]           w_addr_d, w_base, w_base_d;
  logic [BAW-1:0]           b_addr_d, out_addr_d;
  logic [ACT_W-1:0]         out_data_d, q_sat;
  logic                     mac_vld, mac_vld_d;
  logic signed [ACC_W-1:0]  acc, acc_d, acc_sum;
  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  sum, q;

  // The memory data belongs to the address issued in the previous RUN cycle.
  assign prod    = $signed({{(PROD_W-W_W){w_data[W_W-1]}}, w_data})
                 * $signed({{(PROD_W-ACT_W){1'b0}}, act_data});
  assign acc_sum = mac_vld ? acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod} : acc;
  assign sum     = {acc_sum[ACC_W-1], acc_sum} + {{(SUM_W-B_W){b_data[B_W-1]}}, b_data};
  assign q       = sum >>> SHIFT;

  // Requantization clamp: unsigned after ReLU, or signed two's complement.
  always_comb begin
    q_sat = q[ACT_W-1:0];
    if (RELU != 0) begin
      if (q[SUM_W-1])    q_sat = '0;
      else if (q > UMAX) q_sat = '1;
    end else begin
      if (q > SMAX)      q_sat = SMAX[ACT_W-1:0];
      else if (q < SMIN) q_sat = SMIN[ACT_W-1:0];
    end
  end

  always_comb begin
    state_d    = state;
    act_addr_d = act_addr;
    w_addr_d   = w_addr;
    w_base_d   = w_base;
    b_addr_d   = b_addr;
    out_addr_d = out_addr;
    out_data_d = out_data;
    out_wen_d  = 1'b0;
    mac_vld_d  = 1'b0;
    acc_d      = acc_sum;
    case (state)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          act_addr_d = '0;
          w_addr_d   = '0;
          w_base_d   = '0;
          b_addr_d   = '0;
          acc_d      = '0;
        end
      end
      RUN: begin
        mac_vld_d = 1'b1;
        if (act_addr == AW'(N_IN - 1)) begin
          state_d = DRAIN;
        end else begin
          act_addr_d = act_addr + AW'(1);
          w_addr_d   = w_addr + WAW'(1);
        end
      end
      // The last product and the bias land here, so the result is registered entering WRITE.
      DRAIN: begin
        state_d    = WRITE;
        out_wen_d  = 1'b1;
        out_addr_d = b_addr;
        out_data_d = q_sat;
      end
      WRITE: begin
        acc_d      = '0;
        act_addr_d = '0;
        if (b_addr == BAW'(N_OUT - 1)) begin
          state_d = DONE;
        end else begin
          state_d  = RUN;
          b_addr_d = b_addr + BAW'(1);
          w_base_d = w_base + WAW'(N_IN);
          w_addr_d = w_base + WAW'(N_IN);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_wen  <= 1'b0;
      act_addr <= '0;
      w_addr   <= '0;
      w_base   <= '0;
      b_addr   <= '0;
      out_addr <= '0;
      out_data <= '0;
      mac_vld  <= 1'b0;
      acc      <= '0;
    end else begin
      state    <= state_d;
      busy     <= busy_d;
      done     <= done_d;
      out_wen  <= out_wen_d;
      act_addr <= act_addr_d;
      w_addr   <= w_addr_d;
      w_base   <= w_base_d;
      b_addr   <= b_addr_d;
      out_addr <= out_addr_d;
      out_data <= out_data_d;
      mac_vld  <= mac_vld_d;
      acc      <= acc_d;
    end
  end

endmodule

// File: tb/tb_dense_layer_engine.sv
// Scoreboard bench for dense_layer_engine. Three configurations share the same memory
// images and run in lockstep.
module tb_dense_layer_engine;

  localparam int N_IN       = 4;
  localparam int N_OUT      = 2;
  localparam int NCFG       = 3;
  localparam int AW         = $clog2(N_IN);
  localparam int WAW        = $clog2(N_IN * N_OUT);
  localparam int BAW        = $clog2(N_OUT);
  localparam int NEURON_CYC = N_IN + 2;
  localparam int SHIFTS [NCFG] = '{0, 0, 2};
  localparam int RELUS  [NCFG] = '{1, 0, 1};

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;

  logic [3:0]        act_mem [N_IN];
  logic signed [3:0] w_mem   [N_IN*N_OUT];
  logic signed [15:0] b_mem  [N_OUT];

  int errors = 0;
  int checks = 0;
  event issue_ev, flush_ev;

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference neuron: a dot product plus bias, then a shift and a clamp, in plain integers.
  function automatic int ref_out(input int n, input int shift, input int relu);
    int sum, q;
    sum = int'(b_mem[n]);
    for (int k = 0; k < N_IN; k++)
      sum = sum + int'(w_mem[n*N_IN + k]) * int'(act_mem[k]);
    q = sum >>> shift;
    if (relu != 0) q = (q < 0) ? 0 : ((q > 15) ? 15 : q);
    else           q = (q < -8) ? -8 : ((q > 7) ? 7 : q);
    return q & 15;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    logic           busy, done, out_wen;
    logic [AW-1:0]  act_addr;
    logic [WAW-1:0] w_addr;
    logic [BAW-1:0] b_addr, out_addr;
    logic [3:0]     act_data, w_data, out_data;
    logic [15:0]    b_data;
    int exp_q [$];
    int wr_cnt   = 0;
    int done_cnt = 0;

    dense_layer_engine #(
      .N_IN(N_IN), .N_OUT(N_OUT), .ACT_W(4), .W_W(4), .B_W(16), .ACC_W(24),
      .SHIFT(SHIFTS[g]), .RELU(RELUS[g])
    ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .act_addr(act_addr), .act_data(act_data),
      .w_addr(w_addr), .w_data(w_data),
      .b_addr(b_addr), .b_data(b_data),
      .out_wen(out_wen), .out_addr(out_addr), .out_data(out_data)
    );

    // Registered memory models with one cycle of read latency.
    always @(posedge clk) begin
      act_data <= act_mem[act_addr];
      w_data   <= w_mem[w_addr];
      b_data   <= b_mem[b_addr];
    end

    always @(issue_ev)
      for (int n = 0; n < N_OUT; n++)
        exp_q.push_back(n * 16 + ref_out(n, SHIFTS[g], RELUS[g]));

    always @(flush_ev) exp_q.delete();

    always @(negedge clk) begin
      int e;
      if (done) done_cnt++;
      if (out_wen) begin
        wr_cnt++;
        check($sformatf("cfg%0d write expected", g), int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("cfg%0d out_addr", g), int'(out_addr), e / 16);
          check($sformatf("cfg%0d out_data", g), int'(out_data), e % 16);
        end
      end
    end
  end

  // Starts one layer, optionally pulses start again while busy, and checks timing and counts.
  task automatic run_layer(input bit restart);
    int w0, w1, w2, d0, lat;
    w0 = cfg[0].wr_cnt;
    w1 = cfg[1].wr_cnt;
    w2 = cfg[2].wr_cnt;
    d0 = cfg[0].done_cnt;
    lat = 0;
    ->issue_ev;
    start = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      start = (restart && (cyc == 3 || cyc == 8)) ? 1'b1 : 1'b0;
      if (cyc <= N_OUT * NEURON_CYC) begin
        check("busy", int'(cfg[0].busy), 1);
        check("out_wen", int'(cfg[0].out_wen), int'(cyc % NEURON_CYC == 0));
        if ((cyc - 1) % NEURON_CYC < N_IN)
          check("w_addr", int'(cfg[0].w_addr),
                ((cyc - 1) / NEURON_CYC) * N_IN + (cyc - 1) % NEURON_CYC);
      end
      if (cfg[0].done) begin
        lat = cyc;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done latency", lat, N_OUT * NEURON_CYC + 1);
    @(negedge clk);
    check("done after", int'(cfg[0].done), 0);
    check("busy after", int'(cfg[0].busy), 0);
    check("cfg0 writes", cfg[0].wr_cnt - w0, N_OUT);
    check("cfg1 writes", cfg[1].wr_cnt - w1, N_OUT);
    check("cfg2 writes", cfg[2].wr_cnt - w2, N_OUT);
    check("done pulses", cfg[0].done_cnt - d0, 1);
  endtask

  task automatic fill(input int a, input int w, input int b0, input int b1);
    for (int k = 0; k < N_IN; k++) act_mem[k] = 4'(a);
    for (int k = 0; k < N_IN * N_OUT; k++) w_mem[k] = 4'(w);
    b_mem[0] = 16'(b0);
    b_mem[1] = 16'(b1);
  endtask

  task automatic fill_random();
    int t;
    for (int k = 0; k < N_IN; k++) act_mem[k] = 4'($urandom);
    for (int k = 0; k < N_IN * N_OUT; k++) w_mem[k] = 4'($urandom);
    for (int n = 0; n < N_OUT; n++) begin
      t = int'($urandom_range(0, 600)) - 300;
      b_mem[n] = 16'(t);
    end
  endtask

  initial begin
    int w_before;
    fill(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst busy", int'(cfg[0].busy), 0);
    check("rst done", int'(cfg[0].done), 0);
    check("rst out_wen", int'(cfg[0].out_wen), 0);
    check("rst act_addr", int'(cfg[0].act_addr), 0);
    check("rst w_addr", int'(cfg[0].w_addr), 0);
    check("rst b_addr", int'(cfg[0].b_addr), 0);
    check("rst out_addr", int'(cfg[0].out_addr), 0);
    check("rst out_data", int'(cfg[0].out_data), 0);
    rst = 1'b0;
    @(negedge clk);

    fill(1, 1, 0, 3);
    run_layer(1'b0);
    fill(15, -8, 0, 0);
    run_layer(1'b0);
    fill(15, 7, 0, 0);
    run_layer(1'b0);
    fill(0, 1, 3, 3);
    for (int k = 0; k < N_IN; k++) act_mem[k] = 4'(k + 1);
    run_layer(1'b0);

    // Reset during neuron 0 abandons the layer without any write.
    fill_random();
    w_before = cfg[0].wr_cnt;
    ->issue_ev;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ->flush_ev;
    @(negedge clk);
    check("mid rst busy", int'(cfg[0].busy), 0);
    check("mid rst out_wen", int'(cfg[0].out_wen), 0);
    check("mid rst act_addr", int'(cfg[0].act_addr), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("mid rst no write", cfg[0].wr_cnt - w_before, 0);
    fill_random();
    run_layer(1'b0);

    fill(1, 1, 0, 3);
    run_layer(1'b1);

    for (int r = 0; r < 8; r++) begin
      fill_random();
      run_layer(r % 3 == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dense_layer_engine.md
Name: dense_layer_engine

Overview:
- Sequencer/MAC for one fully connected int4 layer of the MNIST engine.
- Reads activations from the upstream activation ram_memory, weights and biases from rom_memory instances, and computes one neuron at a time.
- Requantizes each result and writes it into the next layer's activation ram_memory.
- Sits directly downstream of the weight/activation memories; drives their addresses and consumes their registered 1-cycle-latency data_out.

Parameters:
- N_IN, 784, inputs per neuron (activation RAM depth).
- N_OUT, 10, neurons in the layer (output RAM depth, bias ROM depth).
- ACT_W, 4, activation and output width.
- W_W, 4, signed weight width.
- B_W, 16, signed bias width.
- ACC_W, 24, signed accumulator width.
- SHIFT, 4, arithmetic right shift applied at requantization.
- RELU, 1, 1 = ReLU plus unsigned clamp; 0 = signed clamp.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins the layer when idle.
- busy  out  1  high from the cycle after accepted start through the done cycle.
- done  out  1  one-cycle pulse when the last neuron has been written.
- act_addr  out  $clog2(N_IN)  activation RAM address.
- act_data  in  ACT_W  activation RAM data_out; unsigned, valid 1 cycle after address.
- w_addr  out  $clog2(N_IN*N_OUT)  weight ROM address.
- w_data  in  W_W  weight ROM data_out; signed, 1-cycle latency.
- b_addr  out  $clog2(N_OUT)  bias ROM address; equals the current neuron index.
- b_data  in  B_W  bias ROM data_out; signed, 1-cycle latency.
- out_wen  out  1  output RAM write enable.
- out_addr  out  $clog2(N_OUT)  output RAM address; equals the neuron index.
- out_data  out  ACT_W  requantized neuron result.

Behaviour:
- Reset: state=IDLE.
  - busy, done, out_wen = 0.
  - All addresses, out_data, counters and accumulator = 0.
  - Applies mid-operation as well: the layer is abandoned and no further write occurs.
- FSM states: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE:
  - start=1 → RUN; clear i=0, n=0, w_base=0, acc=0.
  - start is ignored in every other state.
- RUN, one cycle per input:
  - Drive act_addr=i, w_addr=w_base+i, b_addr=n.
  - A 1-cycle-delayed valid flag adds sign_ext(w_data) * zero_ext(act_data) into acc on the cycle after each address issue.
  - The product is signed (W_W+ACT_W+1) bits, sign-extended to ACC_W.
  - i==N_IN-1 → DRAIN.
- DRAIN, 1 cycle: accumulate the product of the last address issued.
- WRITE, 1 cycle:
  - sum = acc + sign_ext(b_data).
  - q = sum >>> SHIFT, arithmetic.
  - RELU=1: q<0 → 0; q>2^ACT_W-1 → 2^ACT_W-1.
  - RELU=0: clamp to [-2^(ACT_W-1), 2^(ACT_W-1)-1], two's complement.
  - Assert out_wen=1, out_addr=n, out_data=q[ACT_W-1:0] in this cycle.
  - Then clear acc, set i=0, w_base+=N_IN (running offset, no multiplier).
  - n==N_OUT-1 → DONE; otherwise n+=1 → RUN.
- DONE: done=1 for exactly one cycle, busy still 1, then → IDLE.
- Latency:
  - N_IN+2 cycles per neuron.
  - The first RUN cycle is the cycle after start is sampled.
  - done is asserted N_OUT*(N_IN+2)+1 cycles after the start edge.
- Ordering:
  - out_wen is never asserted outside WRITE.
  - Outputs are written in ascending out_addr order, exactly once each per layer.
- Overflow: ACC_W must hold N_IN*(2^ACT_W-1)*2^(W_W-1) plus the bias; the default holds for 784 inputs. No wrap detection is required.
- A start coinciding with rst is ignored; reset wins.

Test Plan (N_IN=4, N_OUT=2, SHIFT=0, RELU=1 unless stated; memories are real rom_memory/ram_memory models):
- All activations 1, all weights 1, biases {0,3}, start → writes addr0=4, addr1=7; done one cycle after the second write, 13 cycles after start.
- Activations 15, weights -8, bias 0 → sum -480 → out_data 0 at both addresses (ReLU).
- Activations 15, weights 7, bias 0 → 420 → saturated 15. With RELU=0 → 7; with weights -8 and RELU=0 → -8 (4'h8).
- SHIFT=2, activations {1,2,3,4}, weights {1,1,1,1}, bias 3 → sum 13 → 3.
- rst asserted during neuron 0 RUN → next cycle busy=0, out_wen=0, no write. A fresh start produces correct results from neuron 0.
- start pulsed again while busy → ignored: exactly 2 writes and a single done pulse. Check that w_addr steps 0..3 then 4..7 and that out_wen is high exactly 2 cycles.
